// File: rtl/jump_table_loader.sv
// Writable branch-target/constant table, loaded at boot from a little-endian byte
// stream (two bytes per entry) and read combinationally by the fetch/PC logic.
module jump_table_loader #(
    parameter int unsigned D       = 12,
    parameter int unsigned N       = 32,
    parameter int unsigned HALT_PC = 511
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic [4:0]   rd_addr,
    output logic [D-1:0] rd_target,
    output logic [5:0]   count,
    output logic         done,
    output logic         err
);

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    logic [AW-1:0]  wptr;
    logic [7:0]     lo_reg;
    logic [D-1:0]   tbl [N];
    logic           xfer_c;

    // in_ready is registered alongside state, so a transfer never depends on in_valid timing
    assign xfer_c    = in_valid && in_ready;
    assign rd_target = tbl[rd_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wptr     <= '0;
            lo_reg   <= '0;
            count    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                tbl[i] <= (i == int'(N) - 1) ? D'(HALT_PC) : '0;
            end
        end else if (start) begin
            // start wins over any same-cycle byte; a pending LO byte is simply forgotten
            state    <= LO;
            wptr     <= '0;
            count    <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b0;
                end
                LO: begin
                    if (xfer_c) begin
                        lo_reg <= in_data;
                        state  <= HI;
                    end
                end
                HI: begin
                    if (xfer_c) begin
                        tbl[wptr] <= D'({in_data[3:0], lo_reg});
                        if (in_data[7:4] != 4'd0) begin
                            err <= 1'b1;
                        end
                        count <= count + CW'(1);
                        if (wptr == AW'(N - 1)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            wptr  <= wptr + AW'(1);
                            state <= LO;
                        end
                    end
                end
                DONE: begin
                    in_ready <= 1'b0;
                    done     <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jump_table_loader.sv
// Randomized self-checking bench for jump_table_loader against a byte-stream model.
module tb_jump_table_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic [11:0] rd_target;
    logic [5:0]  count;
    logic        done;
    logic        err;

    int total = 0;
    int bad = 0;

    // reference model: table contents and load progress
    logic [11:0] exp_tab [32];
    logic [7:0]  m_lo;
    bit          m_phase;
    int          m_count;
    bit          m_done;
    bit          m_err;

    jump_table_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .rd_addr(rd_addr),
        .rd_target(rd_target), .count(count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) exp_tab[i] = (i == 31) ? 12'd511 : 12'd0;
        m_phase = 0; m_count = 0; m_done = 0; m_err = 0; m_lo = 8'd0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_phase) begin
            m_lo = b;
            m_phase = 1;
        end else begin
            exp_tab[m_count] = {b[3:0], m_lo};
            if (b[7:4] != 4'd0) m_err = 1;
            m_count++;
            m_phase = 0;
            if (m_count == 32) m_done = 1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        m_phase = 0; m_count = 0; m_done = 0; m_err = 0;
    endtask

    // Presents a byte from the next negedge; returns at the negedge before the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited = 0;
        @(negedge clk);
        if (gaps) begin
            int g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data = b;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_byte timeout: in_ready=%0b required=1", in_ready);
        end else begin
            model_byte(b);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic send_entry(input logic [11:0] v, input bit gaps);
        send_byte(v[7:0], gaps);
        send_byte({4'd0, v[11:8]}, gaps);
    endtask

    task automatic test_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) send_entry(12'($urandom), 0);
        send_byte(8'h77, 0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err); end
        total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", in_ready); end
        rd_addr = 5'd31; #1;
        total++; if (rd_target !== 12'd511) begin bad++; $display("FAIL reset_rd31: got %0d want 511", rd_target); end
        rd_addr = 5'd4; #1;
        total++; if (rd_target !== 12'd0) begin bad++; $display("FAIL reset_rd4: got %0d want 0", rd_target); end
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_full_load();
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            send_entry(12'h100 + 12'(i), 0);
            if (i == 31) begin
                #1;
                total++; if (done !== 1'b0) begin bad++; $display("FAIL full_done_early: got %0b want 0", done); end
                @(posedge clk); #1;
                total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done_edge: got %0b want 1", done); end
            end
        end
        idle();
        total++; if (count !== 6'd32) begin bad++; $display("FAIL full_count: got %0d want 32", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %0b want 0", in_ready); end
        rd_addr = 5'd7; #1;
        total++; if (rd_target !== 12'h107) begin bad++; $display("FAIL full_rd7: got %h want 107", rd_target); end
        rd_addr = 5'd31; #1;
        total++; if (rd_target !== 12'h11F) begin bad++; $display("FAIL full_rd31: got %h want 11f", rd_target); end
        // bytes offered in DONE must be ignored
        @(negedge clk); in_valid = 1'b1; in_data = 8'hFF;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        total++; if (count !== 6'd32 || done !== 1'b1) begin bad++; $display("FAIL done_no_accept: count=%0d done=%0b want 32 1", count, done); end
        rd_addr = 5'd0; #1;
        total++; if (rd_target !== 12'h100) begin bad++; $display("FAIL done_rd0: got %h want 100", rd_target); end
    endtask

    task automatic test_gaps();
        // scramble the table first so the gapped load has to rewrite every entry
        pulse_start();
        for (int i = 0; i < 32; i++) send_entry(12'($urandom), 0);
        idle();
        pulse_start();
        for (int i = 0; i < 32; i++) send_entry(12'h100 + 12'(i), 1);
        idle();
        @(negedge clk);
        total++; if (count !== 6'd32 || done !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL gaps_status: count=%0d done=%0b err=%0b want 32 1 0", count, done, err);
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i); #0.1;
            total++;
            if (rd_target !== exp_tab[i] || exp_tab[i] !== 12'h100 + 12'(i)) begin
                bad++; $display("FAIL gaps_tab[%0d]: got %h want %h", i, rd_target, 12'h100 + 12'(i));
            end
        end
    endtask

    task automatic test_err_nibble();
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            if (i == 3) begin
                send_byte(8'h34, $urandom_range(0, 1) == 1);
                send_byte(8'hA2, 0);
                #1;
                total++; if (err !== 1'b0) begin bad++; $display("FAIL err_early: got %0b want 0", err); end
                @(posedge clk); #1;
                total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %0b want 1", err); end
            end else begin
                send_entry(12'($urandom), $urandom_range(0, 1) == 1);
            end
        end
        idle();
        @(negedge clk);
        total++; if (err !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL err_sticky: err=%0b done=%0b want 1 1", err, done); end
        rd_addr = 5'd3; #1;
        total++; if (rd_target !== 12'h234) begin bad++; $display("FAIL err_tab3: got %h want 234", rd_target); end
        total++; if (rd_target !== exp_tab[3]) begin bad++; $display("FAIL err_model3: got %h want %h", rd_target, exp_tab[3]); end
        pulse_start();
        total++; if (err !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL err_clear: err=%0b done=%0b ready=%0b want 0 0 1", err, done, in_ready);
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 5; i++) send_entry(12'($urandom), 0);
        send_byte(8'($urandom), 0);
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        m_phase = 0; m_count = 0; m_err = 0; m_done = 0;
        total++; if (count !== 6'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL restart_state: count=%0d ready=%0b want 0 1", count, in_ready); end
        for (int i = 1; i <= 4; i++) begin
            rd_addr = 5'(i); #0.1;
            total++; if (rd_target !== exp_tab[i]) begin bad++; $display("FAIL restart_keep[%0d]: got %h want %h", i, rd_target, exp_tab[i]); end
        end
        send_byte(8'h55, 0);
        send_byte(8'h03, 0);
        idle();
        rd_addr = 5'd0; #1;
        total++; if (rd_target !== 12'h355 || exp_tab[0] !== 12'h355) begin bad++; $display("FAIL restart_e0: got %h want 355", rd_target); end
        total++; if (count !== 6'd1) begin bad++; $display("FAIL restart_count: got %0d want 1", count); end
    endtask

    task automatic test_rdw();
        logic [11:0] old2;
        logic [11:0] nv;
        pulse_start();
        send_entry(12'($urandom), 0);
        send_entry(12'($urandom), 0);
        old2 = exp_tab[2];
        nv = 12'($urandom) ^ (old2 & 12'h0F0) ^ 12'h0F0;
        send_byte(nv[7:0], 0);
        rd_addr = 5'd2;
        send_byte({4'd0, nv[11:8]}, 0);
        #1;
        total++; if (rd_target !== old2) begin bad++; $display("FAIL rdw_old: got %h want %h", rd_target, old2); end
        @(posedge clk); #1;
        total++; if (rd_target !== nv) begin bad++; $display("FAIL rdw_new: got %h want %h", rd_target, nv); end
        send_byte(8'($urandom), 0);
        idle();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (rd_target !== 12'd0) begin bad++; $display("FAIL rdw_reset_rd2: got %h want 0", rd_target); end
        total++; if (count !== 6'd0 || in_ready !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rdw_reset_state: count=%0d ready=%0b done=%0b want 0 0 0", count, in_ready, done);
        end
        rd_addr = 5'd31; #1;
        total++; if (rd_target !== 12'd511) begin bad++; $display("FAIL rdw_reset_rd31: got %0d want 511", rd_target); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_full_load();
        test_gaps();
        test_err_nibble();
        test_restart();
        test_rdw();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jump_table_loader.md
Name: jump_table_loader

Overview:
- Writable counterpart to the fixed branch-target/constant lookup table.
- Holds N entries of D-bit targets (LDI constants, absolute branch targets, halt address).
- Entries are loaded at boot from a byte stream via a valid/ready loader FSM.
- The fetch/PC logic reads entries combinationally by 5-bit index, with the same read semantics as the fixed table.

Parameters:
- D, 12, width of each target entry (bits).
- N, 32, number of entries; index width AW = 5 (fixed, N must be 32).
- HALT_PC, 511, reset value of entry N-1 (halt address).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins or restarts a load.
- in_valid  input  1  byte-stream valid.
- in_ready  output  1  loader accepts a byte this cycle.
- in_data  input  8  stream byte.
- rd_addr  input  5  read index.
- rd_target  output  D  combinational read data, table[rd_addr].
- count  output  6  number of entries written since the last start (0..32).
- done  output  1  level; high while all N entries are loaded.
- err  output  1  sticky; a high byte with nonzero bits [7:4] was seen during this load.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, wptr=0, lo_reg=0, count=0, done=0, err=0, in_ready=0.
  - table[0..N-2]=0, table[N-1]=HALT_PC.
  - Reset asserted mid-load discards everything and returns to the reset values.
- Handshake:
  - A byte transfers on a rising edge when in_valid && in_ready.
  - in_ready=1 only in LO and HI states; it is a pure function of state, with no combinational path from in_valid.
  - in_data is ignored when no transfer occurs.
  - Gaps in in_valid of any length are allowed.
- Stream format: two bytes per entry, little-endian, entries in index order 0..N-1.
  - LO byte = target[7:0].
  - HI byte bits [3:0] = target[11:8]; bits [7:4] must be 0.
- States:
  - IDLE: in_ready=0. start -> LO, with wptr=0, count=0, err=0.
  - LO: on transfer, lo_reg<=in_data -> HI.
  - HI: on transfer:
    - table[wptr] <= {in_data[3:0], lo_reg}.
    - if in_data[7:4]!=0, err<=1; the entry is still written with the low nibble.
    - count<=count+1.
    - if wptr==N-1 -> DONE, done<=1; else wptr<=wptr+1 -> LO.
  - DONE: in_ready=0, done=1. start -> LO, with done<=0, wptr=0, count=0, err=0.
- start in LO or HI restarts the load:
  - Return to LO with wptr=0, count=0, err=0.
  - A pending lo_reg is discarded.
  - Entries already written keep their values until overwritten.
  - start has priority over a same-cycle transfer; that byte is dropped.
- Read port:
  - Purely combinational from the registered table.
  - A write lands on the clock edge of the HI transfer and is visible on rd_target immediately after that edge.
  - Same-cycle read of the index being written returns the old value.
- Reads are always permitted, including during a load; partially loaded tables return a mix of new and old/reset values.
- No wrap: wptr never exceeds N-1, and no bytes are accepted in DONE.

Test Plan:
1. Reset: assert reset_n=0 mid-simulation.
   - done=0, err=0, count=0, in_ready=0.
   - rd_addr=31 -> rd_target=511; rd_addr=4 -> 0.
2. Full load: start, then 64 back-to-back bytes giving entry i = 12'h100+i.
   - done rises on the edge of byte 64; count=32.
   - rd_addr=7 -> 12'h107; rd_addr=31 -> 12'h11F; in_ready=0 afterwards.
3. Back-pressure/gaps: in_valid toggled randomly through the same stream.
   - Identical final table to test 2; no byte lost or duplicated.
4. Error nibble: entry 3 HI byte = 8'hA2, LO = 8'h34.
   - err=1 from the next cycle until the next start; table[3]=12'h234.
   - done still reaches 1.
5. Restart mid-load: start pulse after 5 entries plus one LO byte, with a transfer presented the same cycle.
   - count=0, that byte is dropped, next accepted byte is entry 0 LO.
   - Entries 1..4 keep their old values until rewritten.
6. Read-during-write: rd_addr=2 held while entry 2 HI byte transfers.
   - Old value before the edge, new value after; async reset during HI state restores reset values.
